// File: rtl/mac_dot_ctrl_if.sv
// ============================================================================
// mac_dot_ctrl_if : operand stream, MAC drive and result port bundle for
//                   the dot-product sequencer (names are controller-centric).
// Revision: 1.0
// ============================================================================
`default_nettype none

interface mac_dot_ctrl_if #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 8
);
  logic                 i_start;
  logic [LEN_W-1:0]     i_len;
  logic                 o_busy;
  logic                 i_op_valid;
  logic                 o_op_ready;
  logic [WIDTH-1:0]     i_op_a;
  logic [WIDTH-1:0]     i_op_b;
  logic                 o_mac_en;
  logic                 o_mac_clr;
  logic [WIDTH-1:0]     o_mac_a;
  logic [WIDTH-1:0]     o_mac_b;
  logic [2*WIDTH-1:0]   i_mac_out;
  logic                 o_res_valid;
  logic                 i_res_ready;
  logic [2*WIDTH-1:0]   o_res_data;

  modport slave (
    input  i_start, i_len, i_op_valid, i_op_a, i_op_b, i_mac_out, i_res_ready,
    output o_busy, o_op_ready, o_mac_en, o_mac_clr, o_mac_a, o_mac_b,
           o_res_valid, o_res_data
  );

  modport master (
    output i_start, i_len, i_op_valid, i_op_a, i_op_b, i_mac_out, i_res_ready,
    input  o_busy, o_op_ready, o_mac_en, o_mac_clr, o_mac_a, o_mac_b,
           o_res_valid, o_res_data
  );
endinterface

`default_nettype wire

// File: rtl/mac_dot_ctrl.sv
// ============================================================================
// mac_dot_ctrl : sequences one signed dot product through a two-stage
//                mac_unit (clear, feed, drain, capture) and returns the sum.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mac_dot_ctrl #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  mac_dot_ctrl_if.slave   bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RUN     = 3'd1;
  localparam logic [2:0] S_DRAIN   = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_ZERO    = 3'd4;
  localparam logic [2:0] S_RESULT  = 3'd5;

  localparam logic [LEN_W-1:0] c_LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  logic [2:0]         r_state;
  logic [LEN_W-1:0]   r_remaining;
  logic               r_first;
  logic [2*WIDTH-1:0] r_res_data;
  logic               w_hs;

  assign w_hs = (r_state == S_RUN) && bus.i_op_valid;

  // Clearing on the first issue zeroes acc while mult loads p0, so a stale
  // product left in mult by the previous run is never accumulated.
  assign bus.o_busy      = (r_state != S_IDLE);
  assign bus.o_op_ready  = (r_state == S_RUN);
  assign bus.o_mac_en    = w_hs || (r_state == S_DRAIN);
  assign bus.o_mac_clr   = (w_hs && r_first) || (r_state == S_ZERO);
  assign bus.o_mac_a     = w_hs ? bus.i_op_a : '0;
  assign bus.o_mac_b     = w_hs ? bus.i_op_b : '0;
  assign bus.o_res_valid = (r_state == S_RESULT);
  assign bus.o_res_data  = r_res_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_first     <= 1'b0;
      r_res_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_start) begin
            r_remaining <= bus.i_len;
            r_first     <= (bus.i_len != '0);
            r_state     <= (bus.i_len != '0) ? S_RUN : S_ZERO;
          end
        end
        S_RUN: begin
          if (w_hs) begin
            r_remaining <= r_remaining - c_LEN_ONE;
            r_first     <= 1'b0;
            if (r_remaining == c_LEN_ONE) r_state <= S_DRAIN;
          end
        end
        S_DRAIN:   r_state <= S_CAPTURE;
        S_CAPTURE: begin
          r_res_data <= bus.i_mac_out;
          r_state    <= S_RESULT;
        end
        S_ZERO: begin
          r_res_data <= '0;
          r_state    <= S_RESULT;
        end
        S_RESULT: begin
          if (bus.i_res_ready) r_state <= S_IDLE;
        end
        default:   r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mac_dot_ctrl.sv
// ============================================================================
// tb_mac_dot_ctrl : directed bench for mac_dot_ctrl with a behavioural
//                   two-stage MAC attached to its drive port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mac_dot_ctrl;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  mac_dot_ctrl_if #(.WIDTH(16), .LEN_W(8)) bus ();

  mac_dot_ctrl #(.WIDTH(16), .LEN_W(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mac_unit: mult registered on en, acc adds the old mult; clr wins.
  logic signed [31:0] r_mult;
  logic signed [31:0] r_acc;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mult <= '0;
      r_acc  <= '0;
    end else begin
      if (bus.o_mac_en) r_mult <= $signed(bus.o_mac_a) * $signed(bus.o_mac_b);
      if (bus.o_mac_clr)     r_acc <= '0;
      else if (bus.o_mac_en) r_acc <= r_acc + r_mult;
    end
  end
  assign bus.i_mac_out = r_acc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string pfx);
    check({pfx, "_ctl"}, {bus.o_busy, bus.o_op_ready, bus.o_mac_en,
                          bus.o_mac_clr, bus.o_res_valid}, 64'd0);
    check({pfx, "_mab"}, {bus.o_mac_a, bus.o_mac_b}, 64'd0);
    check({pfx, "_res"}, bus.o_res_data, 64'd0);
  endtask

  logic [15:0] va [8];
  logic [15:0] vb [8];
  int          gap[8];

  task automatic clear_vec();
    for (int i = 0; i < 8; i++) begin
      va[i] = '0; vb[i] = '0; gap[i] = 0;
    end
  endtask

  // Cycle 0 samples start; counts are collected per cycle until res_valid.
  task automatic run_dot(input int n, input bit consume, output logic [31:0] res,
                         output int lat, output int en_n, output int clr_n,
                         output int clr_cyc, output int rdy_n);
    int cyc;
    int idx;
    int g;
    en_n = 0; clr_n = 0; clr_cyc = -1; rdy_n = 0; lat = -1; res = '0;
    @(posedge clk); #1;
    bus.i_start = 1'b1; bus.i_len = n[7:0]; bus.i_op_valid = 1'b0;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    cyc = 1; idx = 0; g = gap[0];
    while (cyc < 100) begin
      bus.i_op_a = 16'hDEAD; bus.i_op_b = 16'hBEEF;
      if (idx < n && g > 0) begin
        bus.i_op_valid = 1'b0; g--;
      end else if (idx < n) begin
        bus.i_op_valid = 1'b1; bus.i_op_a = va[idx]; bus.i_op_b = vb[idx];
      end else begin
        bus.i_op_valid = 1'b0;
      end
      #1;
      if (bus.o_mac_en)   en_n++;
      if (bus.o_op_ready) rdy_n++;
      if (bus.o_mac_clr) begin
        clr_n++;
        if (clr_cyc < 0) clr_cyc = cyc;
      end
      if (bus.i_op_valid && bus.o_op_ready) begin
        idx++;
        if (idx < n) g = gap[idx];
      end
      if (bus.o_res_valid) begin
        lat = cyc; res = bus.o_res_data;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.i_op_valid = 1'b0;
    check("res_valid_seen", {63'd0, bus.o_res_valid}, 64'd1);
    if (consume) begin
      bus.i_res_ready = 1'b1;
      @(posedge clk); #1;
      bus.i_res_ready = 1'b0;
      #1;
      check("idle_after_res", {63'd0, bus.o_busy}, 64'd0);
    end
  endtask

  logic [31:0] res;
  logic [31:0] saved;
  int lat, en_n, clr_n, clr_cyc, rdy_n, bad;

  initial begin
    n_tests = 0; n_fail = 0;
    rst_n = 1'b0;
    bus.i_start = 1'b0; bus.i_len = '0; bus.i_op_valid = 1'b0;
    bus.i_op_a = '0; bus.i_op_b = '0; bus.i_res_ready = 1'b0;
    clear_vec();
    repeat (3) @(posedge clk);
    #1 check_quiet("reset");
    #2 rst_n = 1'b1;

    // 2.0 + 2.0 - 3.0 = 1.0
    clear_vec();
    va[0] = 16'h0100; vb[0] = 16'h0200;
    va[1] = 16'h0080; vb[1] = 16'h0400;
    va[2] = 16'hFF00; vb[2] = 16'h0300;
    run_dot(3, 1'b1, res, lat, en_n, clr_n, clr_cyc, rdy_n);
    check("basic_res",     res,     64'h0001_0000);
    check("basic_lat",     lat,     64'd6);
    check("basic_clr_n",   clr_n,   64'd1);
    check("basic_clr_cyc", clr_cyc, 64'd1);
    check("basic_en_n",    en_n,    64'd4);

    clear_vec();
    va[0] = 16'h7FFF; vb[0] = 16'h7FFF;
    run_dot(1, 1'b1, res, lat, en_n, clr_n, clr_cyc, rdy_n);
    check("staleA_res", res, 64'h3FFF_0001);
    check("staleA_lat", lat, 64'd4);
    clear_vec();
    va[0] = 16'h0100; vb[0] = 16'h0100;
    va[1] = 16'h0100; vb[1] = 16'h0100;
    run_dot(2, 1'b1, res, lat, en_n, clr_n, clr_cyc, rdy_n);
    check("staleB_res", res, 64'h0002_0000);
    check("staleB_lat", lat, 64'd5);

    // 2 bubbles before pair 0, 3 between pairs 2 and 3: last issue in cycle 9
    clear_vec();
    for (int i = 0; i < 4; i++) begin va[i] = 16'h0100; vb[i] = 16'h0100; end
    gap[0] = 2; gap[3] = 3;
    run_dot(4, 1'b1, res, lat, en_n, clr_n, clr_cyc, rdy_n);
    check("bub_res",     res,     64'h0004_0000);
    check("bub_en_n",    en_n,    64'd5);
    check("bub_lat",     lat,     64'd12);
    check("bub_clr_n",   clr_n,   64'd1);
    check("bub_clr_cyc", clr_cyc, 64'd3);

    clear_vec();
    run_dot(0, 1'b1, res, lat, en_n, clr_n, clr_cyc, rdy_n);
    check("zero_res",   res,   64'd0);
    check("zero_lat",   lat,   64'd2);
    check("zero_en_n",  en_n,  64'd0);
    check("zero_rdy_n", rdy_n, 64'd0);

    // -2.0*1.5 + 0.25*1.0 = -2.75
    clear_vec();
    va[0] = 16'hFE00; vb[0] = 16'h0180;
    va[1] = 16'h0040; vb[1] = 16'h0100;
    run_dot(2, 1'b0, res, lat, en_n, clr_n, clr_cyc, rdy_n);
    check("bp_res", res, 64'hFFFD_4000);
    saved = res; bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      bus.i_start = (i % 3 == 0); bus.i_len = 8'd5;
      #1;
      if (!bus.o_res_valid || bus.o_res_data !== saved || bus.o_op_ready) bad++;
    end
    check("bp_stable", bad, 64'd0);
    @(posedge clk); #1;
    bus.i_start = 1'b1; bus.i_res_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0; bus.i_res_ready = 1'b0;
    #1 check("bp_idle", {bus.o_busy, bus.o_op_ready, bus.o_res_valid}, 64'd0);
    @(posedge clk); #2;
    check("bp_start_ignored", {63'd0, bus.o_busy}, 64'd0);

    // Abort after 2 of 5 pairs, with op_valid still high
    @(posedge clk); #1;
    bus.i_start = 1'b1; bus.i_len = 8'd5;
    @(posedge clk); #1;
    bus.i_start = 1'b0; bus.i_op_valid = 1'b1;
    bus.i_op_a = 16'h0300; bus.i_op_b = 16'h0300;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_quiet("midrst");
    check("midrst_acc", r_acc, 64'd0);
    bus.i_op_valid = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;

    clear_vec();
    va[0] = 16'h0200; vb[0] = 16'h0300;
    run_dot(1, 1'b1, res, lat, en_n, clr_n, clr_cyc, rdy_n);
    check("postrst_res", res, 64'h0006_0000);
    check("postrst_lat", lat, 64'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/mac_dot_ctrl.md
# mac_dot_ctrl

Upstream sequencer for `mac_unit` that computes one signed dot product of length `len`. It accepts operand pairs on a valid/ready stream and drives `mac_unit`'s `en`, `clr`, `a_in` and `b_in` so that the MAC's two-stage pipeline (multiply register, then accumulate) is cleared, fed and drained correctly. When the sum is complete it captures the MAC output and presents it on a valid/ready result port.

## Interface
- `WIDTH`, 16: operand width in Q8.8; must match `mac_unit` `WIDTH`.
- `LEN_W`, 8: width of the vector-length field; maximum length is 2^LEN_W−1.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low. Same net drives `mac_unit`.
- `start` in 1: begin a dot product; sampled only in IDLE.
- `len` in LEN_W: vector length; sampled with `start`.
- `busy` out 1: high in every state except IDLE.
- `op_valid` in 1: operand pair valid.
- `op_ready` out 1: operand pair accepted when `op_valid` and `op_ready` are both high.
- `op_a`, `op_b` in WIDTH each: signed operands.
- `mac_en` out 1: to `mac_unit` `en`.
- `mac_clr` out 1: to `mac_unit` `clr`.
- `mac_a`, `mac_b` out WIDTH each: to `mac_unit` `a_in` / `b_in`.
- `mac_out` in 2·WIDTH: from `mac_unit` `out` (Q16.16).
- `res_valid` out 1: result valid.
- `res_ready` in 1: result consumer ready.
- `res_data` out 2·WIDTH: signed dot product, registered.

## Operation
**MAC behaviour this block relies on.**
- On an edge with `en` high: `mult <= a*b`.
- On an edge with `clr` high: `acc <= 0`, with priority over accumulation.
- On an edge with `clr` low and `en` high: `acc <= acc + mult`, using the old `mult`.
- `clr` does not clear `mult`, so `mult` can hold a stale product from a previous run.

**States.**
- IDLE:
  - On `start`, load `remaining <= len`.
  - `len` ≠ 0 → RUN, with the `first` flag set.
  - `len` = 0 → ZERO.
- RUN:
  - `op_ready = 1`.
  - On each handshake: `mac_en = 1`, `mac_a = op_a`, `mac_b = op_b`, `remaining` decrements.
  - `mac_clr = 1` only on the first handshake (the `first` flag); this discards the stale product, since `acc` becomes 0 while `mult` loads p0.
  - On the handshake where `remaining` is 1 → DRAIN.
  - With no handshake (`op_valid` low): `mac_en = 0`, and both MAC registers hold.
- DRAIN (1 cycle):
  - `mac_en = 1`, `mac_a = mac_b = 0`.
  - Adds the last product; `mult` is left at 0.
  - → CAPTURE.
- CAPTURE (1 cycle):
  - `mac_en = 0`; `mac_out` is now final.
  - `res_data <= mac_out`.
  - → RESULT.
- ZERO (1 cycle):
  - `mac_clr = 1`, `mac_en = 0`.
  - `res_data <= 0`.
  - → RESULT.
- RESULT:
  - `res_valid = 1`, with `res_data` stable.
  - On `res_ready` → IDLE.

**Output rules.**
- Outside an RUN handshake and DRAIN: `mac_en = 0`, `mac_a = mac_b = 0`.
- `op_ready = 0` outside RUN.
- `start` is ignored while `busy`.

**Arithmetic.**
- No saturation; the 2·WIDTH sum wraps as in the MAC.
- `res_data` is a bit-exact copy of `mac_out`.

## Timing
**Reset values.** Every state resets to IDLE with all outputs 0: `busy`, `op_ready`, `mac_en`, `mac_clr`, `mac_a`, `mac_b`, `res_valid`, `res_data`. The `remaining` counter and the `first` flag also reset to 0.

**Latency.**
- Call cycle 0 the cycle in which `start` is sampled.
- With `op_valid` held high, pairs transfer in cycles 1..N.
- DRAIN occurs in cycle N+1 and CAPTURE in cycle N+2; `res_valid` is high from cycle N+3.
- Generally, `res_valid` rises 3 cycles after the last operand handshake.
- For `len` = 0, `res_valid` rises in cycle 2.

**Handshakes and boundary conditions.**
- `op_ready` is a pure function of state; it never depends combinationally on `op_valid`.
- `res_valid` stays high and `res_data` stays stable until `res_ready`.
- Bubbles (`op_valid` low) in RUN stretch latency 1:1 and do not corrupt the sum.
- A stall before the first handshake must not assert `mac_clr`.
- When `start` and the final `res_ready` fall in the same cycle, `start` is ignored, because the block is still in RESULT. A new `start` is accepted only in the following IDLE cycle.
- Asserting `rst_n` low mid-run aborts immediately: IDLE, all outputs 0, MAC cleared by the same reset. There is no partial result.

## Test plan
- **Basic run.** `len=3`, pairs (1.0,2.0), (0.5,4.0), (−1.0,3.0) (0x0100·0x0200, etc.), `op_valid` held high.
  - Requires `res_data = 0x0001_0000` (1.0 Q16.16).
  - `res_valid` in cycle 6; `mac_clr` only in cycle 1.
- **Stale product.**
  - Run A: `len=1`, (0x7FFF, 0x7FFF).
  - Run B: `len=2`, (0x0100, 0x0100) twice.
  - Run B must yield `0x0002_0000`, with no residue from A.
- **Bubbles.** `len=4`, all pairs (0x0100, 0x0100), `op_valid` low for 2 cycles before pair 0 and 3 cycles between pairs 2 and 3.
  - Requires `0x0004_0000`.
  - `mac_en` high in exactly 5 cycles (4 issues + DRAIN).
- **Zero length.** `len=0`.
  - Requires `res_valid` in cycle 2 and `res_data = 0`.
  - No `op_ready` and no `mac_en` at any point.
- **Result backpressure.** `res_ready` held low for 10 cycles.
  - `res_valid` and `res_data` stable throughout.
  - `start` pulses during the wait are ignored.
  - One cycle after `res_ready`, `busy = 0`.
- **Reset mid-run.** `rst_n` asserted after 2 of 5 pairs.
  - All outputs 0 asynchronously.
  - A fresh `len=1` (0x0200, 0x0300) then yields `0x0006_0000`.
